nla_fifo_stream_reader: RTL and testbench

Downstream consumer of the BRAM-backed sync FIFO. Pops 32-bit operands from the FIFO's read port and absorbs its fixed read latency in an internal skid buffer. Presents them to the nonlinear-approximation engine over a valid/ready stream with frame framing (m_last_o). Prevents lost or duplicated reads under engine backpressure and FIFO write-priority collisions.

---
 rtl/nla_stream_pkg.sv | 29 ++
 rtl/nla_skid_fifo.sv | 74 +++++++
 rtl/nla_fifo_stream_reader.sv | 185 ++++++++++++++++++
 tb/tb_nla_fifo_stream_reader.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nla_stream_pkg.sv
// -----------------------------------------------------------------------------
// nla_stream_pkg
// Shared definitions for the NLA FIFO stream reader:
//   DATA_W        operand width (IEEE-754 single precision)
//   NAN_EXP_MASK  exponent field mask of a single-precision word
//   NAN_MAN_MASK  mantissa field mask of a single-precision word
//   state_t       reader control states {IDLE, RUN, DRAIN}
//   is_nan()      true for exponent all-ones with a non-zero mantissa
// -----------------------------------------------------------------------------
package nla_stream_pkg;

   localparam int DATA_W = 32;

   localparam logic [DATA_W-1:0] NAN_EXP_MASK = 32'h7F80_0000;
   localparam logic [DATA_W-1:0] NAN_MAN_MASK = 32'h007F_FFFF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Infinity (mantissa zero) is deliberately not a NaN.
   function automatic logic is_nan(input logic [DATA_W-1:0] word);
      return ((word & NAN_EXP_MASK) == NAN_EXP_MASK) &&
             ((word & NAN_MAN_MASK) != '0);
   endfunction

endpackage

// File: rtl/nla_skid_fifo.sv
// -----------------------------------------------------------------------------
// nla_skid_fifo
// Small circular buffer that absorbs the FIFO read latency. Each entry carries
// a data word plus a frame-last tag.
// Ports:
//   clk_i, rstn_i            clock, asynchronous active-low reset
//   push, push_data,         write one entry (data + last tag)
//   push_last
//   pop                      remove the head entry (only when count != 0)
//   count                    number of occupied entries (0..DEPTH)
//   head_data, head_last     contents of the head entry
// -----------------------------------------------------------------------------
module nla_skid_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk_i,
   input  logic                       rstn_i,
   input  logic                       push,
   input  logic [W-1:0]               push_data,
   input  logic                       push_last,
   input  logic                       pop,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic [W-1:0]               head_data,
   output logic                       head_last
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [W:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] cnt_q;

   // Explicit wrap so DEPTH need not be a power of two.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of its sources, independent of block order.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else begin
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop)  rd_ptr <= next_ptr(rd_ptr);
         unique case ({push, pop})
            2'b10:   cnt_q <= cnt_q + CNT_W'(1);
            2'b01:   cnt_q <= cnt_q - CNT_W'(1);
            default: cnt_q <= cnt_q;   // idle, or push and pop together
         endcase
      end
   end

   // NOTE: the storage array has no reset; occupancy is tracked by cnt_q, and
   // the consumer masks the head whenever the buffer is empty.
   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= {push_last, push_data};
   end

   assign {head_last, head_data} = mem[rd_ptr];
   assign count                  = cnt_q;

   // Upstream credit accounting reserves a slot for every read in flight.
   a_no_overflow  : assert property (@(posedge clk_i) disable iff (!rstn_i)
                                     !(push && cnt_q == CNT_W'(DEPTH)));
   a_no_underflow : assert property (@(posedge clk_i) disable iff (!rstn_i)
                                     !(pop && cnt_q == '0));

endmodule

// File: rtl/nla_fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// nla_fifo_stream_reader
// Pops operands from a BRAM-backed sync FIFO (fixed read latency), absorbs the
// latency in a skid buffer and presents words to the nonlinear-approximation
// engine as a valid/ready stream with frame framing.
// Optional build macro: NLA_NAN_FLUSH_EN -- replaces NaN words with +0.0 on
// buffer entry and counts them on nan_cnt_o (tied to zero when undefined).
// Ports:
//   clk_i, rstn_i      clock, asynchronous active-low reset
//   enable_i           high = run; low = stop issuing reads and drain
//   frame_len_i        words per frame, captured when leaving IDLE (0 = no last)
//   fifo_empty_i       FIFO empty flag
//   fifo_wr_en_i       FIFO write enable (a write masks a same-cycle read)
//   fifo_data_i        FIFO read data, valid RD_LATENCY cycles after a read
//   fifo_rd_en_o       FIFO read request
//   m_valid_o/m_data_o/m_last_o/m_ready_i   output stream
//   busy_o             high in RUN or DRAIN
//   nan_cnt_o          saturating count of flushed NaN words
// -----------------------------------------------------------------------------
module nla_fifo_stream_reader #(
   parameter int DATA_W     = 32,
   parameter int RD_LATENCY = 2,
   parameter int BUF_DEPTH  = 4,
   parameter int LEN_W      = 16
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              enable_i,
   input  logic [LEN_W-1:0]  frame_len_i,
   input  logic              fifo_empty_i,
   input  logic              fifo_wr_en_i,
   input  logic [DATA_W-1:0] fifo_data_i,
   output logic              fifo_rd_en_o,
   output logic              m_valid_o,
   output logic [DATA_W-1:0] m_data_o,
   output logic              m_last_o,
   input  logic              m_ready_i,
   output logic              busy_o,
   output logic [15:0]       nan_cnt_o
);

   import nla_stream_pkg::*;

   localparam int CNT_W = $clog2(BUF_DEPTH + 1);
   localparam int INF_W = $clog2(RD_LATENCY + 1);
   localparam int SUM_W = CNT_W + 1;

   if (BUF_DEPTH < RD_LATENCY + 2) begin : g_depth_check
      $error("nla_fifo_stream_reader: BUF_DEPTH must be >= RD_LATENCY+2");
   end

   state_t              state_q, state_d;
   logic                start;
   logic                rd_en;
   logic                credit_ok;
   logic [RD_LATENCY-1:0] rd_sr;
   logic [INF_W-1:0]    inflight;
   logic [CNT_W-1:0]    count;
   logic                push;
   logic [DATA_W-1:0]   push_data;
   logic                last_tag;
   logic                beat;
   logic [DATA_W-1:0]   head_data;
   logic                head_last;
   logic [LEN_W-1:0]    frame_len_q;
   logic [LEN_W-1:0]    word_cnt_q;

   // Reads in flight are exactly the set bits of the return shift register.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
         inflight = inflight + INF_W'(rd_sr[i]);
      end
   end

   // Credit uses this cycle's occupancy; a same-cycle pop frees its slot only
   // from the next cycle on.
   assign credit_ok = (SUM_W'(inflight) + SUM_W'(count)) < SUM_W'(BUF_DEPTH);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // NOTE: every signal written here receives a default first, so no path
   // leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      rd_en   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (enable_i) begin
               state_d = RUN;
               start   = 1'b1;
            end
         end
         RUN: begin
            // The FIFO drops a read that collides with a write, so never ask.
            rd_en = !fifo_empty_i && !fifo_wr_en_i && credit_ok;
            if (!enable_i) state_d = DRAIN;
         end
         DRAIN: begin
            // Empty buffer implies no beat can be in progress.
            if (inflight == '0 && count == '0) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign fifo_rd_en_o = rd_en;
   assign busy_o       = (state_q != IDLE);

   // ------------------------------------------------------- return path
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         rd_sr <= '0;
      end else begin
         rd_sr[0] <= rd_en;
         for (int i = 1; i < RD_LATENCY; i++) rd_sr[i] <= rd_sr[i-1];
      end
   end

   assign push = rd_sr[RD_LATENCY-1];

   // ----------------------------------------------------------- framing
   // The last tag is decided when a word enters the buffer.
   assign last_tag = (frame_len_q != '0) && ((word_cnt_q + LEN_W'(1)) == frame_len_q);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         frame_len_q <= '0;
         word_cnt_q  <= '0;
      end else if (start) begin
         frame_len_q <= frame_len_i;
         word_cnt_q  <= '0;
      end else if (push) begin
         word_cnt_q  <= last_tag ? '0 : word_cnt_q + LEN_W'(1);
      end
   end

   // --------------------------------------------------------- NaN flush
`ifdef NLA_NAN_FLUSH_EN
   logic [15:0] nan_cnt_q;
   logic        in_nan;

   assign in_nan    = is_nan(fifo_data_i);
   assign push_data = in_nan ? '0 : fifo_data_i;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i)                                   nan_cnt_q <= '0;
      else if (push && in_nan && nan_cnt_q != 16'hFFFF) nan_cnt_q <= nan_cnt_q + 16'd1;
   end

   assign nan_cnt_o = nan_cnt_q;
`else
   assign push_data = fifo_data_i;
   assign nan_cnt_o = '0;
`endif

   // ------------------------------------------------------- skid buffer
   assign beat = m_valid_o && m_ready_i;

   nla_skid_fifo #(
      .W     (DATA_W),
      .DEPTH (BUF_DEPTH)
   ) u_skid (
      .clk_i     (clk_i),
      .rstn_i    (rstn_i),
      .push      (push),
      .push_data (push_data),
      .push_last (last_tag),
      .pop       (beat),
      .count     (count),
      .head_data (head_data),
      .head_last (head_last)
   );

   // Head is masked while empty so the unreset storage never reaches the port.
   assign m_valid_o = (count != '0);
   assign m_data_o  = m_valid_o ? head_data : '0;
   assign m_last_o  = m_valid_o && head_last;

endmodule

// File: tb/tb_nla_fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_nla_fifo_stream_reader
// Self-checking bench for nla_fifo_stream_reader. A queue models the FIFO
// (fixed two-cycle read data) and a second queue holds the words the engine
// must receive, in write order; framing and NaN flushing are computed from
// the beat index and the word value.
// -----------------------------------------------------------------------------
module tb_nla_fifo_stream_reader;

   localparam int DATA_W     = 32;
   localparam int RD_LATENCY = 2;
   localparam int BUF_DEPTH  = 4;
   localparam int LEN_W      = 16;

   logic              clk_i        = 1'b0;
   logic              rstn_i       = 1'b0;
   logic              enable_i     = 1'b0;
   logic [LEN_W-1:0]  frame_len_i  = '0;
   logic              fifo_empty_i = 1'b1;
   logic              fifo_wr_en_i = 1'b0;
   logic [DATA_W-1:0] fifo_data_i  = '0;
   logic              fifo_rd_en_o;
   logic              m_valid_o;
   logic [DATA_W-1:0] m_data_o;
   logic              m_last_o;
   logic              m_ready_i    = 1'b0;
   logic              busy_o;
   logic [15:0]       nan_cnt_o;

   nla_fifo_stream_reader #(
      .DATA_W     (DATA_W),
      .RD_LATENCY (RD_LATENCY),
      .BUF_DEPTH  (BUF_DEPTH),
      .LEN_W      (LEN_W)
   ) dut (
      .clk_i        (clk_i),
      .rstn_i       (rstn_i),
      .enable_i     (enable_i),
      .frame_len_i  (frame_len_i),
      .fifo_empty_i (fifo_empty_i),
      .fifo_wr_en_i (fifo_wr_en_i),
      .fifo_data_i  (fifo_data_i),
      .fifo_rd_en_o (fifo_rd_en_o),
      .m_valid_o    (m_valid_o),
      .m_data_o     (m_data_o),
      .m_last_o     (m_last_o),
      .m_ready_i    (m_ready_i),
      .busy_o       (busy_o),
      .nan_cnt_o    (nan_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // ------------------------------------------------------------ model
   logic [31:0] fifo_q[$];   // contents of the modelled FIFO
   logic [31:0] exp_q[$];    // words the engine must see, in order
   logic [31:0] pipe1, pipe2; // read data one / two cycles old
   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int reads = 0;
   int beats = 0;
   int beat_no = 0;
   int nan_exp = 0;
   int cur_len = 0;
   int first_rd_cyc = -1;
   int first_vld_cyc = -1;
   int last_beat_cyc = -1;
   bit stall_prev = 1'b0;
   logic [31:0] stall_data = '0;
   logic stall_last = 1'b0;

   function automatic bit model_nan(input logic [31:0] w);
`ifdef NLA_NAN_FLUSH_EN
      return (w[30:23] == 8'hFF) && (w[22:0] != 23'd0);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] model_out(input logic [31:0] w);
      return model_nan(w) ? 32'h0000_0000 : w;
   endfunction

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      w = $urandom();
      if ($urandom_range(7) == 0) begin
         w[30:23] = 8'hFF;
         if ($urandom_range(1) == 0) w[22:0] = 23'd0;      // infinity
         else if (w[22:0] == 23'd0) w[22:0] = 23'd1;       // NaN
      end
      return w;
   endfunction

   task automatic preload(input logic [31:0] w);
      fifo_q.push_back(w);
      exp_q.push_back(model_out(w));
   endtask

   task automatic clear_model();
      fifo_q.delete();
      exp_q.delete();
      pipe1 = $urandom();
      pipe2 = $urandom();
      stall_prev = 1'b0;
      reads = 0;
      beats = 0;
   endtask

   task automatic begin_run(input int len);
      frame_len_i   = LEN_W'(len);
      cur_len       = len;
      beat_no       = 0;
      first_rd_cyc  = -1;
      first_vld_cyc = -1;
      last_beat_cyc = -1;
   endtask

   // One clock cycle: drive at the falling edge, sample 1 time unit later,
   // then advance the FIFO model for the coming rising edge.
   task automatic step(input logic en, input logic rdy, input logic wr);
      logic [31:0] rd_word, exp_w, w;
      logic        exp_last;
      @(negedge clk_i);
      enable_i     = en;
      m_ready_i    = rdy;
      fifo_wr_en_i = wr;
      fifo_empty_i = (fifo_q.size() == 0);
      fifo_data_i  = pipe2;
      #1;
      cyc++;
      if (wr) begin
         n_cmp++;
         if (fifo_rd_en_o !== 1'b0) begin
            n_err++;
            $display("FAIL rd_wr_collision: rd_en=%b while wr_en=1 (want 0) cyc %0d", fifo_rd_en_o, cyc);
         end
      end
      if (fifo_empty_i) begin
         n_cmp++;
         if (fifo_rd_en_o !== 1'b0) begin
            n_err++;
            $display("FAIL rd_on_empty: rd_en=%b while empty (want 0) cyc %0d", fifo_rd_en_o, cyc);
         end
      end
      rd_word = $urandom();
      if (fifo_rd_en_o === 1'b1 && fifo_q.size() != 0) begin
         rd_word = fifo_q.pop_front();
         reads++;
         if (first_rd_cyc < 0) first_rd_cyc = cyc;
         if (model_nan(rd_word)) nan_exp++;
      end
      if (stall_prev) begin
         n_cmp++;
         if (m_valid_o !== 1'b1 || m_data_o !== stall_data || m_last_o !== stall_last) begin
            n_err++;
            $display("FAIL stall_hold: got v=%b d=%h l=%b want v=1 d=%h l=%b cyc %0d",
                     m_valid_o, m_data_o, m_last_o, stall_data, stall_last, cyc);
         end
      end
      if (m_valid_o === 1'b1 && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (m_valid_o === 1'b1 && rdy) begin
         beats++;
         beat_no++;
         last_beat_cyc = cyc;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL beat_extra: got d=%h with no word outstanding cyc %0d", m_data_o, cyc);
         end else begin
            exp_w    = exp_q.pop_front();
            exp_last = (cur_len != 0) && (beat_no % cur_len == 0);
            if (m_data_o !== exp_w || m_last_o !== exp_last) begin
               n_err++;
               $display("FAIL beat: got d=%h l=%b want d=%h l=%b (beat %0d) cyc %0d",
                        m_data_o, m_last_o, exp_w, exp_last, beat_no, cyc);
            end
         end
      end
      stall_prev = (m_valid_o === 1'b1) && !rdy;
      stall_data = m_data_o;
      stall_last = m_last_o;
      n_cmp++;
      if (reads - beats > BUF_DEPTH) begin
         n_err++;
         $display("FAIL occupancy: got %0d words held want <= %0d cyc %0d", reads - beats, BUF_DEPTH, cyc);
      end
      if (wr) begin
         w = rand_word();
         fifo_q.push_back(w);
         exp_q.push_back(model_out(w));
      end
      pipe2 = pipe1;
      pipe1 = rd_word;
   endtask

   task automatic run_until_empty(input int ready_pct, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         step(1'b1, ($urandom_range(99) < ready_pct), 1'b0);
         n++;
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL deliver_timeout: got %0d words undelivered want 0", exp_q.size());
      end
   endtask

   task automatic drain_to_idle();
      int n = 0;
      do begin
         step(1'b0, 1'b1, 1'b0);
         n++;
      end while (busy_o !== 1'b0 && n < 40);
      n_cmp++;
      if (busy_o !== 1'b0) begin
         n_err++;
         $display("FAIL drain_timeout: got busy=%b want 0", busy_o);
      end
      n_cmp++;
      if (nan_cnt_o !== 16'(nan_exp)) begin
         n_err++;
         $display("FAIL nan_count: got %0d want %0d", nan_cnt_o, nan_exp);
      end
   endtask

   // ------------------------------------------------------------ tests
   task automatic test_reset();
      enable_i     = 1'b1;
      fifo_empty_i = 1'b0;
      m_ready_i    = 1'b1;
      #12;
      n_cmp++;
      if ({fifo_rd_en_o, m_valid_o, m_last_o, busy_o} !== 4'b0000) begin
         n_err++;
         $display("FAIL reset_ctrl: got rd/v/l/busy=%b want 0000", {fifo_rd_en_o, m_valid_o, m_last_o, busy_o});
      end
      n_cmp++;
      if (m_data_o !== 32'h0) begin
         n_err++;
         $display("FAIL reset_data: got %h want 00000000", m_data_o);
      end
      n_cmp++;
      if (nan_cnt_o !== 16'h0) begin
         n_err++;
         $display("FAIL reset_nan: got %0d want 0", nan_cnt_o);
      end
      @(negedge clk_i);
      enable_i = 1'b0;
      rstn_i   = 1'b1;
      clear_model();
   endtask

   task automatic test_basic();
      for (int i = 0; i < 8; i++) preload(32'h3F80_0000 + 32'(i));
      begin_run(4);
      run_until_empty(100, 40);
      n_cmp++;
      if (first_vld_cyc - first_rd_cyc != RD_LATENCY + 1) begin
         n_err++;
         $display("FAIL latency: got %0d cycles want %0d", first_vld_cyc - first_rd_cyc, RD_LATENCY + 1);
      end
      n_cmp++;
      if (last_beat_cyc - first_vld_cyc != 7) begin
         n_err++;
         $display("FAIL throughput: got 8 beats over %0d cycles want 8", last_beat_cyc - first_vld_cyc + 1);
      end
      drain_to_idle();
   endtask

   task automatic test_stall();
      int rd_mark;
      clear_model();
      for (int i = 0; i < 16; i++) preload($urandom());
      begin_run(5);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
      rd_mark = reads;
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (reads != rd_mark) begin
         n_err++;
         $display("FAIL stall_rd_en: got %0d reads during stall want 0", reads - rd_mark);
      end
      n_cmp++;
      if (reads - beats != BUF_DEPTH) begin
         n_err++;
         $display("FAIL stall_fill: got %0d buffered want %0d", reads - beats, BUF_DEPTH);
      end
      run_until_empty(100, 60);
      drain_to_idle();
   endtask

   task automatic test_collision();
      clear_model();
      for (int i = 0; i < 4; i++) preload($urandom());
      begin_run(int'($urandom_range(7, 1)));
      for (int i = 0; i < 60; i++) step(1'b1, ($urandom_range(3) != 0), logic'(i % 2));
      run_until_empty(100, 80);
      drain_to_idle();
   endtask

   task automatic test_drain();
      int n = 0;
      clear_model();
      for (int i = 0; i < 6; i++) preload($urandom());
      begin_run(3);
      step(1'b1, 1'b1, 1'b0);
      while (reads == 0 && n < 10) begin
         step(1'b1, 1'b1, 1'b0);
         n++;
      end
      step(1'b0, 1'b1, 1'b0);   // FSM still in RUN this cycle
      drain_to_idle();
      n_cmp++;
      if (reads != 2 || beats != 2) begin
         n_err++;
         $display("FAIL drain_words: got reads=%0d beats=%0d want 2 and 2", reads, beats);
      end
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (reads != 2 || busy_o !== 1'b0) begin
         n_err++;
         $display("FAIL idle_quiet: got reads=%0d busy=%b want 2 and 0", reads, busy_o);
      end
      clear_model();
   endtask

   task automatic test_reset_mid();
      clear_model();
      for (int i = 0; i < 3; i++) preload($urandom());
      begin_run(2);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (m_valid_o !== 1'b1 || reads != 3) begin
         n_err++;
         $display("FAIL pre_reset_fill: got valid=%b reads=%0d want 1 and 3", m_valid_o, reads);
      end
      @(negedge clk_i);
      rstn_i   = 1'b0;
      enable_i = 1'b0;
      #1;
      n_cmp++;
      if ({m_valid_o, m_last_o, busy_o, fifo_rd_en_o} !== 4'b0000 || m_data_o !== 32'h0) begin
         n_err++;
         $display("FAIL async_reset: got v/l/busy/rd=%b d=%h want 0000 00000000",
                  {m_valid_o, m_last_o, busy_o, fifo_rd_en_o}, m_data_o);
      end
      @(negedge clk_i);
      rstn_i  = 1'b1;
      nan_exp = 0;
      clear_model();
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (busy_o !== 1'b0 || m_valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL post_reset_idle: got busy=%b valid=%b want 0 0", busy_o, m_valid_o);
      end
      preload(32'h4000_0000);
      preload(32'h4040_0000);
      begin_run(2);
      run_until_empty(100, 20);
      drain_to_idle();
   endtask

   task automatic test_nan();
      clear_model();
      preload(32'h7FC0_0000);
      preload(32'h7F80_0000);
      preload(32'hFFC0_0001);
      preload(32'h3F80_0000);
      preload(32'hFF80_0000);
      preload(32'h7F80_0001);
      begin_run(0);   // no word may carry the last flag
      run_until_empty(70, 60);
      drain_to_idle();
   endtask

   task automatic test_random();
      clear_model();
      for (int i = 0; i < 5; i++) preload(rand_word());
      begin_run(int'($urandom_range(6)));
      for (int i = 0; i < 300; i++) step(1'b1, ($urandom_range(3) != 0), ($urandom_range(9) < 3));
      run_until_empty(100, 200);
      drain_to_idle();
   endtask

   initial begin
      pipe1 = $urandom();
      pipe2 = $urandom();
      test_reset();
      test_basic();
      test_stall();
      test_collision();
      test_drain();
      test_reset_mid();
      test_nan();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
